// File: rtl/cpu_read_port.sv
// cpu_read_port: 8051 multiplexed-bus read responder with a sample FIFO
// Ports:
//   clock, rst_n          system clock (posedge) and async active-low reset
//   cs_n, abus, ale, r_n  8051 chip select, high address byte, ALE and read strobe
//   dbus_in               data bus as seen by the chip (low address byte during ALE)
//   dbus_out, dbus_oe     read data and its output enable for the top-level tristate
//   y_valid, y            filter output sample strobe and value, pushed into the FIFO
//   fifo_count            FIFO occupancy, 0..DEPTH
//   data_ready            FIFO not empty
module cpu_read_port #(
    parameter int          DEPTH     = 16,
    parameter int          AW        = 4,
    parameter logic [15:0] BASE_ADDR = 16'h8000,
    parameter logic [7:0]  ID_VALUE  = 8'hA5
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          cs_n,
    input  logic [7:0]    abus,
    input  logic          ale,
    input  logic          r_n,
    input  logic [7:0]    dbus_in,
    output logic [7:0]    dbus_out,
    output logic          dbus_oe,
    input  logic          y_valid,
    input  logic [7:0]    y,
    output logic [AW:0]   fifo_count,
    output logic          data_ready
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRIVE = 1'b1;

    // Control pipes: bit 0 = stage 1, bit 1 = stage 2, bit 2 = stage-3 copy for edge detection
    logic [2:0]    cs_p, ale_p, r_p;
    logic [7:0]    abus_s1, abus_s2, dbus_s1, dbus_s2;
    logic [15:0]   addr;
    logic [0:0]    state;
    logic          overflow;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [7:0]    mem [DEPTH];
    logic          ale_fall, r_fall, r_rise, cs_rise, hit, empty, full;
    logic          finish, pop, push, ovf_set, clr_ovf;
    logic [1:0]    off;
    logic [4:0]    cnt_sat;
    logic [7:0]    read_byte;
    logic [AW:0]   count_nxt;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cs_p    <= 3'b111;
            ale_p   <= 3'b111;
            r_p     <= 3'b111;
            abus_s1 <= '0;
            abus_s2 <= '0;
            dbus_s1 <= '0;
            dbus_s2 <= '0;
        end else begin
            cs_p    <= {cs_p[1:0], cs_n};
            ale_p   <= {ale_p[1:0], ale};
            r_p     <= {r_p[1:0], r_n};
            abus_s1 <= abus;
            abus_s2 <= abus_s1;
            dbus_s1 <= dbus_in;
            dbus_s2 <= dbus_s1;
        end
    end

    assign ale_fall = ~ale_p[1] & ale_p[2];
    assign r_fall   = ~r_p[1] & r_p[2];
    assign r_rise   = r_p[1] & ~r_p[2];
    assign cs_rise  = cs_p[1] & ~cs_p[2];
    assign hit      = addr[15:2] == BASE_ADDR[15:2];
    assign off      = addr[1:0];
    assign empty    = fifo_count == '0;
    assign full     = fifo_count == (AW+1)'(DEPTH);
    assign cnt_sat  = (32'(fifo_count) > 32'd31) ? 5'd31 : 5'(fifo_count);

    always_comb begin
        read_byte = off == 2'd0 ? (empty ? 8'h00 : mem[rd_ptr]) :
                    off == 2'd1 ? {empty, full, overflow, cnt_sat} :
                    off == 2'd2 ? 8'h00 : ID_VALUE;
    end

    // r_n rise takes precedence over a simultaneous cs_n rise, so that strobe completes normally
    assign finish    = (state == DRIVE) & r_rise;
    assign pop       = finish & (off == 2'd0) & ~empty;
    assign clr_ovf   = finish & (off == 2'd1);
    // A pop in the same clock frees a slot, so a push while full is still accepted
    assign push      = y_valid & (~full | pop);
    assign ovf_set   = y_valid & full & ~pop;
    assign count_nxt = fifo_count + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (ale_fall && !cs_p[1]) begin
            addr <= {abus_s2, dbus_s2};
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dbus_out <= '0;
            dbus_oe  <= 1'b0;
        end else if (state == IDLE) begin
            if (r_fall && !cs_p[1] && hit) begin
                dbus_out <= read_byte;
                dbus_oe  <= 1'b1;
                state    <= DRIVE;
            end
        end else if (r_rise || cs_rise) begin
            dbus_oe <= 1'b0;
            state   <= IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= y;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            data_ready <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= count_nxt;
            data_ready <= count_nxt != '0;
            overflow   <= ovf_set | (overflow & ~clr_ovf);
        end
    end
endmodule

// File: tb/tb_cpu_read_port.sv
// tb_cpu_read_port: directed table-driven bench for cpu_read_port
module tb_cpu_read_port;
    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs_n = 1'b1;
    logic [7:0] abus = '0;
    logic       ale = 1'b0;
    logic       r_n = 1'b1;
    logic [7:0] dbus_in = '0;
    logic [7:0] dbus_out;
    logic       dbus_oe;
    logic       y_valid = 1'b0;
    logic [7:0] y = '0;
    logic [4:0] fifo_count;
    logic       data_ready;

    int errors = 0;
    int checks = 0;

    cpu_read_port dut (
        .clock(clock), .rst_n(rst_n), .cs_n(cs_n), .abus(abus), .ale(ale), .r_n(r_n),
        .dbus_in(dbus_in), .dbus_out(dbus_out), .dbus_oe(dbus_oe), .y_valid(y_valid),
        .y(y), .fifo_count(fifo_count), .data_ready(data_ready)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] addr;
        bit          exp_oe;
        logic [7:0]  exp_data;
        logic [4:0]  exp_count;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic push_sample(input logic [7:0] v);
        y_valid = 1'b1;
        y = v;
        @(negedge clock);
        y_valid = 1'b0;
    endtask

    task automatic latch_addr(input logic [15:0] a);
        cs_n = 1'b0;
        abus = a[15:8];
        dbus_in = a[7:0];
        ale = 1'b1;
        repeat (2) @(negedge clock);
        ale = 1'b0;
        repeat (4) @(negedge clock);
        dbus_in = '0;
    endtask

    task automatic do_read(input logic [15:0] a, input int hold, input bit pp, input logic [7:0] pv,
                           output logic [7:0] data, output int first_oe, output int drop);
        latch_addr(a);
        first_oe = 0;
        drop = 0;
        r_n = 1'b0;
        for (int k = 1; k <= hold; k++) begin
            @(negedge clock);
            if (dbus_oe && first_oe == 0) first_oe = k;
        end
        data = dbus_out;
        r_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            if (k == 3 && pp) begin
                y_valid = 1'b1;
                y = pv;
            end
            @(negedge clock);
            y_valid = 1'b0;
            if (!dbus_oe && drop == 0) drop = k;
            if (dbus_oe && first_oe == 0) first_oe = 100 + k;
        end
        cs_n = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        logic [7:0] d;
        int fo, dr;
        tbl[0] = '{16'h8001, 1'b1, 8'h03, 5'd3};
        tbl[1] = '{16'h8000, 1'b1, 8'h11, 5'd2};
        tbl[2] = '{16'h8000, 1'b1, 8'h22, 5'd1};
        tbl[3] = '{16'h8000, 1'b1, 8'h33, 5'd0};
        tbl[4] = '{16'h8001, 1'b1, 8'h80, 5'd0};
        tbl[5] = '{16'h8002, 1'b1, 8'h00, 5'd0};
        tbl[6] = '{16'h8003, 1'b1, 8'hA5, 5'd0};
        tbl[7] = '{16'h8000, 1'b1, 8'h00, 5'd0};
        tbl[8] = '{16'h8004, 1'b0, 8'h00, 5'd0};
        tbl[9] = '{16'h7FFF, 1'b0, 8'h00, 5'd0};

        repeat (3) @(negedge clock);
        chk("reset_oe", dbus_oe, 0);
        chk("reset_out", dbus_out, 0);
        chk("reset_count", fifo_count, 0);
        chk("reset_ready", data_ready, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clock);

        do_read(16'h8003, 10, 1'b0, 8'h00, d, fo, dr);
        chk("id_first_oe", fo, 3);
        chk("id_data", d, 8'hA5);
        chk("id_drop_within_3", (dr > 0 && dr <= 3), 1);

        push_sample(8'h11);
        push_sample(8'h22);
        push_sample(8'h33);
        chk("ready_after_push", data_ready, 1);
        for (int i = 0; i < 10; i++) begin
            do_read(tbl[i].addr, 10, 1'b0, 8'h00, d, fo, dr);
            chk($sformatf("vec%0d_oe", i), (fo != 0), tbl[i].exp_oe);
            if (tbl[i].exp_oe) chk($sformatf("vec%0d_data", i), d, tbl[i].exp_data);
            chk($sformatf("vec%0d_count", i), fifo_count, tbl[i].exp_count);
            chk($sformatf("vec%0d_ready", i), data_ready, tbl[i].exp_count != 0);
        end

        for (int i = 0; i < 17; i++) push_sample(8'h40 + 8'(i));
        chk("ovf_count", fifo_count, 16);
        do_read(16'h8001, 10, 1'b0, 8'h00, d, fo, dr);
        chk("ovf_status1", d, 8'h70);
        do_read(16'h8001, 10, 1'b0, 8'h00, d, fo, dr);
        chk("ovf_status2", d, 8'h50);
        for (int i = 0; i < 16; i++) begin
            do_read(16'h8000, 10, 1'b0, 8'h00, d, fo, dr);
            chk($sformatf("ovf_data%0d", i), d, 8'h40 + 8'(i));
        end
        do_read(16'h8000, 10, 1'b0, 8'h00, d, fo, dr);
        chk("ovf_17th_absent", d, 8'h00);
        chk("ovf_end_count", fifo_count, 0);

        for (int i = 0; i < 5; i++) push_sample(8'h60 + 8'(i));
        chk("sim_pre_count", fifo_count, 5);
        do_read(16'h8000, 10, 1'b1, 8'h99, d, fo, dr);
        chk("sim_data", d, 8'h60);
        chk("sim_count", fifo_count, 5);
        do_read(16'h8000, 10, 1'b0, 8'h00, d, fo, dr);
        chk("sim_next_data", d, 8'h61);
        chk("sim_next_count", fifo_count, 4);

        latch_addr(16'h8000);
        r_n = 1'b0;
        repeat (6) @(negedge clock);
        chk("abort_oe", dbus_oe, 1);
        chk("abort_data", dbus_out, 8'h62);
        cs_n = 1'b1;
        dr = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (!dbus_oe && dr == 0) dr = k;
        end
        chk("abort_drop_within_3", (dr > 0 && dr <= 3), 1);
        r_n = 1'b1;
        repeat (6) @(negedge clock);
        chk("abort_count", fifo_count, 4);
        do_read(16'h8000, 10, 1'b0, 8'h00, d, fo, dr);
        chk("abort_no_pop_data", d, 8'h62);

        latch_addr(16'h8003);
        r_n = 1'b0;
        repeat (5) @(negedge clock);
        chk("rst_mid_oe_before", dbus_oe, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_oe", dbus_oe, 0);
        chk("rst_mid_count", fifo_count, 0);
        chk("rst_mid_ready", data_ready, 0);
        r_n = 1'b1;
        cs_n = 1'b1;
        @(negedge clock);
        rst_n = 1'b1;
        repeat (4) @(negedge clock);
        chk("rst_mid_after_oe", dbus_oe, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cpu_read_port.md
Name: cpu_read_port

Overview:
- CPU-facing read responder on the 8051 multiplexed bus; the read-side counterpart of the filter configuration write path.
- Buffers filter output samples (y) in a FIFO.
- Responds to 8051 read cycles (r_n strobe) by driving result, status and ID bytes onto the data bus.
- Sits beside the address latch in the chip top level; the top level owns the dbus tristate using dbus_out/dbus_oe.

Parameters:
- DEPTH, 16, FIFO depth in samples (power of 2).
- AW, 4, log2(DEPTH).
- BASE_ADDR, 16'h8000, base of the 4-byte read window.
- ID_VALUE, 8'hA5, constant returned at offset 3.

Ports:
- clock  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- cs_n  input  1  8051 chip select, active low.
- abus  input  8  8051 high address byte.
- ale  input  1  address latch enable; falling edge latches address.
- r_n  input  1  8051 read strobe, active low.
- dbus_in  input  8  data bus as seen by the chip; low address byte during ALE.
- dbus_out  output  8  read data to drive onto dbus.
- dbus_oe  output  1  top level drives dbus = dbus_out when 1.
- y_valid  input  1  one-clock pulse; filter output sample valid.
- y  input  8  filter output sample.
- fifo_count  output  AW+1  current FIFO occupancy.
- data_ready  output  1  FIFO not empty.

Behaviour:
- Reset: dbus_out=0, dbus_oe=0, fifo_count=0, data_ready=0, overflow=0, latched addr=0, FSM=IDLE, synchroniser stages=inactive (cs_n/ale/r_n=1; abus/dbus_in stages=0).
- Synchronisation: cs_n, ale, r_n, abus, dbus_in each pass through an identical 2-flop pipeline. Edges are detected between stage 2 and a stage-3 copy; bus values are taken from stage 2, aligned with the edge.
- Address latch: on synchronised ale falling edge with synchronised cs_n=0, addr <= {abus, dbus_in}. Otherwise addr holds.
- Hit: addr[15:2] == BASE_ADDR[15:2]. Offset = addr[1:0].
- Read map:
  - Offset 0: FIFO head data, or 0x00 if empty.
  - Offset 1: status = {empty, full, overflow, count[4:0]}; count saturates at 5 bits.
  - Offset 2: 0x00.
  - Offset 3: ID_VALUE.
- FSM IDLE:
  - Synchronised r_n fall with cs_n=0 and hit: capture read byte into dbus_out, set dbus_oe=1, go DRIVE.
  - dbus_oe rises 3 clocks after the raw r_n fall.
  - No hit: stay IDLE; dbus_oe stays 0.
- FSM DRIVE:
  - dbus_out is frozen for the whole strobe.
  - Synchronised r_n rise: dbus_oe=0, go IDLE, and apply the side effect in that same clock.
    - Offset 0 and FIFO not empty: pop.
    - Offset 1: clear overflow.
  - Synchronised cs_n rise before r_n rise: dbus_oe=0, go IDLE, no side effect.
- FIFO push: y_valid=1 and not full pushes y.
  - y_valid while full: sample dropped, overflow set (sticky).
  - Overflow set and status-read clear in the same clock: set wins.
- Simultaneous push and pop: both occur; count unchanged.
  - When full, a push coinciding with a pop is accepted and overflow does not set.
- Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.
- data_ready = (fifo_count != 0), registered with the count.
- Reset asserted mid-read: immediately dbus_oe=0, FIFO emptied, FSM=IDLE.

Test Plan:
- ID read: ALE latch 0x8003, r_n low 10 clocks → dbus_oe=1 from the 3rd clock after the fall, dbus_out=0xA5; dbus_oe=0 within 3 clocks of r_n rise.
- Data: push 0x11, 0x22, 0x33; read offset 1 → 0x03; three offset-0 reads → 0x11, 0x22, 0x33; final status → 0x80, data_ready=0.
- Overflow: push 17 samples → status 0x70 (full, overflow, count 16); second status read → 0x50; the 17th sample is absent from the read-out.
- Empty pop: read offset 0 on empty FIFO → 0x00, fifo_count stays 0, no pointer change.
- Simultaneous: hold fifo_count=5; y_valid pulse in the same clock as the r_n-rise pop of offset 0 → fifo_count stays 5, next read returns the following sample.
- Abort/miss: cs_n rises mid-DRIVE on offset 0 → dbus_oe=0, no pop (count unchanged). Read at 0x8004 or 0x7FFF → dbus_oe never asserts.
